// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_e        : converter FSM states
//   bcd_digit_t    : one packed BCD digit
//   ADD3_THRESHOLD : digit value at which double-dabble adds 3 before a shift
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned ADD3_THRESHOLD = 5;

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble correction for a single BCD digit.
//   digit_i : digit value before the shift
//   digit_o : digit + 3 when digit_i >= ADD3_THRESHOLD, else digit_i unchanged
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  always_comb begin
    if (32'(digit_i) >= ADD3_THRESHOLD) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/seq_binary_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : input handshake, in_data is WIDTH-bit unsigned
//   out_valid/out_ready   : output handshake
//   out_bcd               : DIGITS packed BCD digits, ones digit in [3:0]
//   out_ndigits           : number of significant digits (1 for zero)
//   out_overflow          : value did not fit in DIGITS digits; out_bcd holds low digits
module seq_binary_to_bcd
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4*DIGITS-1:0]           out_bcd,
  output logic [$clog2(DIGITS+1)-1:0]   out_ndigits,
  output logic                          out_overflow
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned NdW  = $clog2(DIGITS + 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [NdW-1:0]      ndig_q, ndig_d;

  logic [4*DIGITS-1:0] adj_digits;
  logic [4*DIGITS-1:0] digits_next;
  logic                carry_out;
  logic [NdW-1:0]      ndig_calc;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (digits_q[4*g +: 4]),
      .digit_o (adj_digits[4*g +: 4])
    );
  end

  // One shift step of {digits, shift register}; the bit shifted out of the
  // top digit is lost from out_bcd and instead flags overflow.
  assign digits_next = {adj_digits[4*DIGITS-2:0], shift_q[WIDTH-1]};
  assign carry_out   = adj_digits[4*DIGITS-1];

  // Significant-digit count of the value being produced by this shift, so it
  // can be registered on the same edge as the final digits.
  always_comb begin
    ndig_calc = NdW'(1);
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (digits_next[4*i +: 4] != 4'd0) begin
        ndig_calc = NdW'(i + 1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    ndig_d   = ndig_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          shift_d  = in_data;
          digits_d = '0;
          ovf_d    = 1'b0;
          cnt_d    = CntW'(WIDTH);
          state_d  = StShift;
        end
      end
      StShift: begin
        digits_d = digits_next;
        shift_d  = shift_q << 1;
        cnt_d    = cnt_q - CntW'(1);
        if (carry_out) begin
          ovf_d = 1'b1;
        end
        if (cnt_q == CntW'(1)) begin
          ndig_d  = ndig_calc;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      digits_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      ndig_q   <= NdW'(1);
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      ndig_q   <= ndig_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StDone);
  assign out_bcd      = digits_q;
  assign out_ndigits  = ndig_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// Self-checking bench for seq_binary_to_bcd: four instances with different
// WIDTH/DIGITS, checked against a decimal arithmetic reference model.
module tb_seq_binary_to_bcd;

  localparam int NInst = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid  [NInst];
  logic [31:0] in_data   [NInst];
  logic        out_ready [NInst];
  logic        in_ready  [NInst];
  logic        out_valid [NInst];
  logic        out_ovf   [NInst];
  logic [39:0] out_bcd   [NInst];
  logic [3:0]  out_nd    [NInst];

  logic [19:0] bcd0;
  logic [2:0]  nd0;
  logic [7:0]  bcd1;
  logic [1:0]  nd1;
  logic [11:0] bcd2;
  logic [1:0]  nd2;
  logic [3:0]  bcd3;
  logic [0:0]  nd3;

  assign out_bcd[0] = {20'b0, bcd0};
  assign out_nd[0]  = {1'b0, nd0};
  assign out_bcd[1] = {32'b0, bcd1};
  assign out_nd[1]  = {2'b0, nd1};
  assign out_bcd[2] = {28'b0, bcd2};
  assign out_nd[2]  = {2'b0, nd2};
  assign out_bcd[3] = {36'b0, bcd3};
  assign out_nd[3]  = {3'b0, nd3};

  int n_tests = 0;
  int n_fail  = 0;
  int n_res2  = 0;

  always #5 clk = ~clk;

  seq_binary_to_bcd #(.WIDTH(16), .DIGITS(5)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][15:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_bcd(bcd0), .out_ndigits(nd0), .out_overflow(out_ovf[0])
  );
  seq_binary_to_bcd #(.WIDTH(8), .DIGITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][7:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_bcd(bcd1), .out_ndigits(nd1), .out_overflow(out_ovf[1])
  );
  seq_binary_to_bcd #(.WIDTH(8), .DIGITS(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][7:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_bcd(bcd2), .out_ndigits(nd2), .out_overflow(out_ovf[2])
  );
  seq_binary_to_bcd #(.WIDTH(1), .DIGITS(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3][0:0]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_bcd(bcd3), .out_ndigits(nd3), .out_overflow(out_ovf[3])
  );

  // Completed handshakes on the exhaustive instance, to catch lost/duplicate results.
  always @(posedge clk) begin
    if (rst_n && out_valid[2] && out_ready[2]) n_res2++;
  end

  function automatic int width_of(input int k);
    case (k)
      0: return 16;
      1: return 8;
      2: return 8;
      default: return 1;
    endcase
  endfunction

  function automatic int digits_of(input int k);
    case (k)
      0: return 5;
      1: return 2;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference: low d digits of v, digit count of that remainder, overflow.
  task automatic ref_model(input longint unsigned v, input int d, output logic [39:0] bcd,
                           output int nd, output bit ovf);
    longint unsigned lim = 1;
    longint unsigned r;
    for (int i = 0; i < d; i++) lim = lim * 10;
    ovf = (v >= lim);
    r   = v % lim;
    bcd = '0;
    nd  = 1;
    for (int i = 0; i < d; i++) begin
      bcd[4*i +: 4] = 4'(r % 10);
      if (r % 10 != 0) nd = i + 1;
      r = r / 10;
    end
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    while (!in_ready[k] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready[k]) check_eq($sformatf("k%0d in_ready timeout", k), 64'(in_ready[k]), 64'd1);
  endtask

  task automatic convert(input int k, input longint unsigned v, input int stall);
    logic [39:0] eb;
    int          en;
    bit          eo;
    int          lat;
    ref_model(v, digits_of(k), eb, en, eo);
    wait_ready(k);
    in_valid[k] = 1'b1;
    in_data[k]  = 32'(v);
    @(posedge clk); #1;
    // Keep offering junk while busy; it must be ignored.
    in_data[k] = $urandom;
    lat = 1;
    while (!out_valid[k] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq($sformatf("k%0d v=%0d latency", k, v), 64'(lat), 64'(width_of(k) + 1));
    check_eq($sformatf("k%0d v=%0d bcd", k, v), 64'(out_bcd[k]), 64'(eb));
    check_eq($sformatf("k%0d v=%0d ndigits", k, v), 64'(out_nd[k]), 64'(en));
    check_eq($sformatf("k%0d v=%0d overflow", k, v), 64'(out_ovf[k]), 64'(eo));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check_eq($sformatf("k%0d v=%0d stall valid", k, v), 64'(out_valid[k]), 64'd1);
      check_eq($sformatf("k%0d v=%0d stall bcd", k, v), 64'(out_bcd[k]), 64'(eb));
      check_eq($sformatf("k%0d v=%0d stall ndigits", k, v), 64'(out_nd[k]), 64'(en));
      check_eq($sformatf("k%0d v=%0d stall in_ready", k, v), 64'(in_ready[k]), 64'd0);
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    check_eq($sformatf("k%0d v=%0d released valid", k, v), 64'(out_valid[k]), 64'd0);
    check_eq($sformatf("k%0d v=%0d released ready", k, v), 64'(in_ready[k]), 64'd1);
  endtask

  initial begin
    bit seen_valid;
    for (int k = 0; k < NInst; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b0;
    end

    // Reset wins over a simultaneous input handshake.
    in_valid[0] = 1'b1;
    in_data[0]  = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset in_ready", 64'(in_ready[0]), 64'd1);
    check_eq("reset out_valid", 64'(out_valid[0]), 64'd0);
    check_eq("reset bcd", 64'(out_bcd[0]), 64'd0);
    check_eq("reset ndigits", 64'(out_nd[0]), 64'd1);
    check_eq("reset overflow", 64'(out_ovf[0]), 64'd0);
    in_valid[0] = 1'b0;
    rst_n = 1'b1;

    // out_ready outside DONE is a no-op.
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check_eq("idle out_ready valid", 64'(out_valid[0]), 64'd0);

    convert(0, 0, 0);
    convert(0, 65535, 0);
    convert(0, 1234, 5);
    for (int i = 0; i < 8; i++) convert(0, 64'($urandom_range(0, 65535)), int'($urandom_range(0, 2)));

    convert(1, 100, 0);
    convert(1, 99, 1);
    convert(1, 255, 0);
    convert(1, 7, 0);

    convert(3, 0, 0);
    convert(3, 1, 1);

    // Reset on shift edge 7 of 4321 discards the conversion.
    wait_ready(0);
    in_valid[0] = 1'b1;
    in_data[0]  = 32'd4321;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("midreset in_ready", 64'(in_ready[0]), 64'd1);
    check_eq("midreset out_valid", 64'(out_valid[0]), 64'd0);
    check_eq("midreset bcd", 64'(out_bcd[0]), 64'd0);
    seen_valid = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen_valid = 1'b1;
    end
    check_eq("midreset no partial result", 64'(seen_valid), 64'd0);
    convert(0, 42, 0);

    n_res2 = 0;
    for (int v = 0; v < 256; v++) convert(2, 64'(v), int'($urandom_range(0, 3)));
    @(posedge clk); #1;
    check_eq("exhaustive result count", 64'(n_res2), 64'd256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_binary_to_bcd.md
SEQ_BINARY_TO_BCD -- requirements
Module: seq_binary_to_bcd

Interface
REQ-001 Parameter WIDTH, default 16: binary input width, legal range 1..32.
REQ-002 Parameter DIGITS, default 5: number of BCD output digits, legal range 1..10.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: reset is synchronous and active-low.
REQ-005 in_valid  input  1: in_data holds a value to convert.
REQ-006 in_ready  output  1: block can accept a new value.
REQ-007 in_data  input  WIDTH: unsigned binary value.
REQ-008 out_valid  output  1: out_bcd, out_ndigits and out_overflow hold a completed result.
REQ-009 out_ready  input  1: consumer accepts the result.
REQ-010 out_bcd  output  4*DIGITS: packed BCD; digit 0 (ones) sits in bits [3:0].
REQ-011 out_ndigits  output  $clog2(DIGITS+1): count of significant digits; value 0 gives 1.
REQ-012 out_overflow  output  1: in_data >= 10^DIGITS; out_bcd then holds the low DIGITS digits of the decimal value.

Function
REQ-013 FSM states: IDLE, SHIFT, DONE.
REQ-014 IDLE: in_ready=1 and out_valid=0.
REQ-015 IDLE->SHIFT on an edge with in_valid&&in_ready; at that edge the FSM latches in_data into the shift register, clears the digit register, clears overflow and loads the bit counter with WIDTH.
REQ-016 SHIFT, each edge: every digit >=5 gets +3; then {digits, shift register} shifts left 1; the counter decrements.
REQ-017 SHIFT->DONE on the edge where the counter reaches 0; exactly WIDTH shift edges occur.
REQ-018 out_valid rises in the cycle after the last shift edge, so latency from the accept edge to out_valid = WIDTH+1 cycles.
REQ-019 SHIFT and DONE: in_ready=0; in_valid and in_data are ignored.
REQ-020 DONE: out_valid=1; out_bcd, out_ndigits and out_overflow stay stable until the edge with out_ready=1, after which the FSM returns to IDLE.
REQ-021 Back-to-back conversions are not overlapped; peak throughput is one result per WIDTH+2 cycles.
REQ-022 Overflow is sticky: it sets on any shift edge where the bit leaving digit DIGITS-1 bit 3 is 1.
REQ-023 out_ndigits = index of the highest nonzero digit +1, or 1 if all digits are zero; it is registered with the result and has no extra latency.
REQ-024 out_ready asserted outside DONE has no effect.
REQ-025 WIDTH=1 is legal and gives 1 shift cycle.

Reset
REQ-026 rst_n=0 at an edge: state=IDLE, in_ready=1, out_valid=0, out_bcd=0, out_ndigits=1, out_overflow=0, counter=0.
REQ-027 Reset during SHIFT or DONE discards the conversion; no partial result is ever presented.
REQ-028 Reset has priority over any handshake in the same cycle.

Structure
REQ-029 Package bcd_pkg holds the state enum type, the BCD digit typedef (4 bits) and the constant ADD3_THRESHOLD=5.
REQ-030 Sub-module bcd_digit_adj holds the combinational per-digit add-3 correction and is instantiated DIGITS times in a generate loop.
REQ-031 No multipliers or dividers are used; the datapath is shift-and-add only.

Verification
REQ-032 Defaults, in_data=0 accepted -> out_valid 17 cycles later, out_bcd=0x00000, out_ndigits=1, out_overflow=0.
REQ-033 Defaults, in_data=65535 -> out_bcd=0x65535, out_ndigits=5, out_overflow=0, latency exactly 17 cycles.
REQ-034 in_data=1234 with out_ready held low 5 cycles after out_valid -> out_bcd=0x01234 and out_ndigits=4 stay stable; in_ready stays 0 until the cycle after the out_ready edge.
REQ-035 WIDTH=8, DIGITS=2: in_data=100 -> out_overflow=1, out_bcd=0x00; in_data=99 -> out_overflow=0, out_bcd=0x99, out_ndigits=2.
REQ-036 rst_n low for 1 cycle at shift edge 7 of a conversion of 4321 -> next cycle state IDLE, out_valid=0, in_ready=1; a following conversion of 42 yields 0x00042.
REQ-037 Exhaustive run with WIDTH=8, DIGITS=3, all 256 inputs and random out_ready stalls -> every result matches a decimal reference model, and no result is lost or duplicated.
